// File: rtl/dbg_axi_master_if.sv
// AXI4-lite-style debug peripheral bus: 4-bit IDs, 32-bit address, 64-bit data.
// The initiator uses the master modport and the peripheral uses the slave modport.
interface dbg_axi_master_if;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWID, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARID, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY,
               RID, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWID, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARID, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY,
               RID, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/dbg_axi_master.sv
// Single-outstanding debug-port initiator: one command in, one AXI transaction, one response out.
// Optional sticky phase timeout enabled by defining DBG_AXI_MASTER_TIMEOUT_EN.
module dbg_axi_master #(
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [3:0]  ID_INIT = 4'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [63:0] cmd_wdata,
    input  logic [7:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [63:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        id_err,
    output logic        timeout,
    dbg_axi_master_if.master axi
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RSP
    } state_t;

    state_t      state;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wr;
    logic        aw_valid;
    logic        w_valid;
    logic        b_ready;
    logic        ar_valid;
    logic        r_ready;

    assign axi.AWID    = id;
    assign axi.AWADDR  = addr;
    assign axi.AWVALID = aw_valid;
    assign axi.WDATA   = wdata;
    assign axi.WSTRB   = wstrb;
    assign axi.WVALID  = w_valid;
    assign axi.BREADY  = b_ready;
    assign axi.ARID    = id;
    assign axi.ARADDR  = addr;
    assign axi.ARVALID = ar_valid;
    assign axi.RREADY  = r_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            id_err    <= 1'b0;
            id        <= ID_INIT;
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            wr        <= 1'b0;
            aw_valid  <= 1'b0;
            w_valid   <= 1'b0;
            b_ready   <= 1'b0;
            ar_valid  <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr      <= cmd_addr;
                        wdata     <= cmd_wdata;
                        wstrb     <= cmd_wstrb;
                        wr        <= cmd_wr;
                        if (cmd_wr) begin
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                            state    <= WADDR;
                        end else begin
                            ar_valid <= 1'b1;
                            state    <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    // AW and W complete independently; leave once both are done.
                    if (axi.AWREADY) aw_valid <= 1'b0;
                    if (axi.WREADY)  w_valid  <= 1'b0;
                    if ((!aw_valid || axi.AWREADY) && (!w_valid || axi.WREADY)) begin
                        b_ready <= 1'b1;
                        state   <= WRESP;
                    end
                end
                WRESP: begin
                    if (axi.BVALID) begin
                        b_ready   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_wr    <= wr;
                        rsp_rdata <= '0;
                        rsp_resp  <= axi.BRESP;
                        if (axi.BID != id) id_err <= 1'b1;
                        state     <= RSP;
                    end
                end
                RADDR: begin
                    if (axi.ARREADY) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= RDATA;
                    end
                end
                RDATA: begin
                    if (axi.RVALID) begin
                        r_ready   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_wr    <= wr;
                        rsp_rdata <= axi.RDATA;
                        rsp_resp  <= axi.RRESP;
                        if (axi.RID != id) id_err <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        id        <= id + 4'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DBG_AXI_MASTER_TIMEOUT_EN
    state_t      last_state;
    logic [31:0] tcnt;
    logic [31:0] tcnt_nxt;
    logic        waiting;

    assign waiting = (state == WADDR) || (state == WRESP) ||
                     (state == RADDR) || (state == RDATA);

    // Counter tracks the state one cycle behind, so the first cycle in a new
    // phase loads 1 rather than clearing; the count equals cycles spent there.
    always_comb begin
        tcnt_nxt = '0;
        if (waiting) begin
            if (state != last_state)  tcnt_nxt = 32'd1;
            else if (tcnt < TIMEOUT)  tcnt_nxt = tcnt + 32'd1;
            else                      tcnt_nxt = tcnt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_state <= IDLE;
            tcnt       <= '0;
            timeout    <= 1'b0;
        end else begin
            last_state <= state;
            tcnt       <= tcnt_nxt;
            if (waiting && (tcnt_nxt >= TIMEOUT)) timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_axi_master.sv
// Directed bench for dbg_axi_master: bench-driven AXI slave, hand-computed expectations.
// Define DBG_AXI_MASTER_TIMEOUT_EN to exercise the timeout flag with TIMEOUT=16.
module tb_dbg_axi_master;

`ifdef DBG_AXI_MASTER_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic [7:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_wr;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        id_err;
    logic        timeout;

    int vectors = 0;
    int miscompares = 0;

    dbg_axi_master_if bus ();

    dbg_axi_master #(.TIMEOUT(16), .ID_INIT(4'h0)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_wr    (rsp_wr),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .id_err    (id_err),
        .timeout   (timeout),
        .axi       (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [63:0] d,
                         input logic [7:0] s);
        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) tick();
        chk("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp(input logic [1:0] er, input logic ew, input logic [63:0] ed);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_wr", rsp_wr, ew);
        chk("rsp_resp", rsp_resp, er);
        chk("rsp_rdata", rsp_rdata, ed);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
    endtask

    task automatic simple_write(input logic [31:0] a, input logic [63:0] d,
                                input logic [7:0] s, input logic [3:0] eid);
        issue(1'b1, a, d, s);
        chk("awvalid", bus.AWVALID, 1);
        chk("wvalid", bus.WVALID, 1);
        chk("awid", bus.AWID, eid);
        chk("awaddr", bus.AWADDR, a);
        chk("wdata", bus.WDATA, d);
        chk("wstrb", bus.WSTRB, s);
        bus.AWREADY = 1'b1;
        bus.WREADY  = 1'b1;
        tick();
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        chk("awvalid_drop", bus.AWVALID, 0);
        chk("wvalid_drop", bus.WVALID, 0);
        chk("bready", bus.BREADY, 1);
        bus.BVALID = 1'b1;
        bus.BID    = eid;
        bus.BRESP  = 2'b00;
        tick();
        bus.BVALID = 1'b0;
        chk("bready_drop", bus.BREADY, 0);
        finish_rsp(2'b00, 1'b1, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
        bus.BID = '0; bus.BRESP = '0; bus.BVALID = 1'b0;
        bus.ARREADY = 1'b0;
        bus.RID = '0; bus.RDATA = '0; bus.RRESP = '0; bus.RVALID = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_awvalid", bus.AWVALID, 0);
        chk("rst_wvalid", bus.WVALID, 0);
        chk("rst_bready", bus.BREADY, 0);
        chk("rst_arvalid", bus.ARVALID, 0);
        chk("rst_rready", bus.RREADY, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        chk("rst_id_err", id_err, 0);
        chk("rst_timeout", timeout, 0);
        RST = 1'b0;

        // Write, AW and W accepted together, ID 0
        simple_write(32'h2000_0000, 64'h41, 8'hFF, 4'h0);

        // Write with AWREADY three cycles ahead of WREADY, ID 1
        issue(1'b1, 32'h2000_0008, 64'h1234, 8'h0F);
        chk("t2_awid", bus.AWID, 1);
        bus.AWREADY = 1'b1;
        tick();
        bus.AWREADY = 1'b0;
        chk("t2_awvalid_drop", bus.AWVALID, 0);
        chk("t2_wvalid_hold", bus.WVALID, 1);
        tick();
        tick();
        chk("t2_wvalid_hold2", bus.WVALID, 1);
        chk("t2_wdata_stable", bus.WDATA, 64'h1234);
        chk("t2_bready_early", bus.BREADY, 0);
        bus.WREADY = 1'b1;
        tick();
        bus.WREADY = 1'b0;
        chk("t2_wvalid_drop", bus.WVALID, 0);
        chk("t2_bready", bus.BREADY, 1);
        bus.BVALID = 1'b1;
        bus.BID    = 4'h1;
        bus.BRESP  = 2'b00;
        tick();
        chk("t2_bready_drop", bus.BREADY, 0);
        tick();
        chk("t2_no_second_b", bus.BREADY, 0);
        bus.BVALID = 1'b0;
        finish_rsp(2'b00, 1'b1, 64'h0);
        bus.BVALID = 1'b1;
        tick();
        chk("stray_b_idle", bus.BREADY, 0);
        bus.BVALID = 1'b0;

        // Read with SLVERR, response held under back-pressure, ID 2
        issue(1'b0, 32'h2000_0010, 64'h0, 8'h00);
        chk("t3_arvalid", bus.ARVALID, 1);
        chk("t3_arid", bus.ARID, 2);
        chk("t3_araddr", bus.ARADDR, 32'h2000_0010);
        chk("t3_awvalid_idle", bus.AWVALID, 0);
        bus.ARREADY = 1'b1;
        tick();
        bus.ARREADY = 1'b0;
        chk("t3_arvalid_drop", bus.ARVALID, 0);
        chk("t3_rready", bus.RREADY, 1);
        bus.RVALID = 1'b1;
        bus.RID    = 4'h2;
        bus.RDATA  = 64'hDEADBEEF_00000001;
        bus.RRESP  = 2'b10;
        tick();
        bus.RVALID = 1'b0;
        bus.RDATA  = '0;
        bus.RRESP  = '0;
        chk("t3_rready_drop", bus.RREADY, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_valid", rsp_valid, 1);
            chk("t3_hold_rdata", rsp_rdata, 64'hDEADBEEF_00000001);
            chk("t3_hold_resp", rsp_resp, 2'b10);
            tick();
        end
        finish_rsp(2'b10, 1'b0, 64'hDEADBEEF_00000001);

        // Reset while waiting in WRESP, ID 3 in flight
        issue(1'b1, 32'h2000_0000, 64'h55, 8'hFF);
        chk("t5_awid", bus.AWID, 3);
        bus.AWREADY = 1'b1;
        bus.WREADY  = 1'b1;
        tick();
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        chk("t5_bready", bus.BREADY, 1);
        tick();
        #2;
        RST = 1'b1;
        #1;
        chk("t5_awvalid", bus.AWVALID, 0);
        chk("t5_wvalid", bus.WVALID, 0);
        chk("t5_bready_async", bus.BREADY, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_cmd_ready", cmd_ready, 0);
        tick();
        RST = 1'b0;

        // 17 writes from ID_INIT: IDs 0..15 then wrap to 0
        for (int i = 0; i < 17; i++)
            simple_write(32'h2000_0020, 64'(i), 8'hFF, 4'(i));
        chk("t4_id_err_clean", id_err, 0);

        // Wrong RID on ID 1 sets sticky id_err
        issue(1'b0, 32'h2000_0020, 64'h0, 8'h00);
        chk("t4_arid", bus.ARID, 1);
        bus.ARREADY = 1'b1;
        tick();
        bus.ARREADY = 1'b0;
        bus.RVALID = 1'b1;
        bus.RID    = 4'h5;
        bus.RDATA  = 64'h77;
        bus.RRESP  = 2'b00;
        tick();
        bus.RVALID = 1'b0;
        chk("t4_id_err_set", id_err, 1);
        finish_rsp(2'b00, 1'b0, 64'h77);
        simple_write(32'h2000_0010, 64'h1, 8'h01, 4'h2);
        chk("t4_id_err_sticky", id_err, 1);

        // BVALID withheld in WRESP, ID 3
        issue(1'b1, 32'h2000_0008, 64'h99, 8'h01);
        bus.AWREADY = 1'b1;
        bus.WREADY  = 1'b1;
        tick();
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("t6_timeout_15", timeout, 0);
        chk("t6_bready_wait", bus.BREADY, 1);
        tick();
        chk("t6_timeout_16", timeout, TO_EN);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_timeout_hold", timeout, TO_EN);
        bus.BVALID = 1'b1;
        bus.BID    = 4'h3;
        bus.BRESP  = 2'b00;
        tick();
        bus.BVALID = 1'b0;
        finish_rsp(2'b00, 1'b1, 64'h0);
        chk("t6_timeout_sticky", timeout, TO_EN);
        chk("t6_id_err_sticky", id_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
